// File: rtl/io_timer_if.sv
// Processor bus bundle for the io_timer peripheral: address, write data/strobe
// out of the CPU, registered read data and select back into its DIN mux.
interface io_timer_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] RDATA;
    logic        SEL;

    modport master (output ADDR, output DOUT, output W, input RDATA, input SEL);
    modport slave  (input ADDR, input DOUT, input W, output RDATA, output SEL);
endinterface

// File: rtl/io_timer.sv
// Memory-mapped down-counter with optional auto-reload and an Expired flag.
// Define IO_TIMER_PRESCALE_EN to divide ticks by PRESCALE; otherwise every RUN cycle ticks.
module io_timer #(
    parameter logic [3:0] BASE     = 4'h4,
    parameter int         PRESCALE = 50000000
) (
    input  logic        Clock,
    input  logic        Resetn,
    io_timer_if.slave   bus,
    output logic        Expired
);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("io_timer: PRESCALE must be at least 2");
    end

    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic        run_q, run_d;
    logic        auto_q, auto_d;
    logic        expired_q, expired_d;
    logic        reload_q, reload_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sel_q, sel_d;

    logic        hit;
    logic [1:0]  offset;
    logic        load_wr;
    logic        ctrl_wr;
    logic        tick;
    logic        expire_now;
    logic [15:0] reg_mux;

    wire unused_addr = &{1'b0, bus.ADDR[11:2]};

`ifdef IO_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] presc_q, presc_d;
    logic          presc_wrap;

    assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
    assign tick       = run_q & presc_wrap;
`else
    assign tick = run_q;
`endif

    assign hit     = (bus.ADDR[15:12] == BASE);
    assign offset  = bus.ADDR[1:0];
    assign load_wr = hit & bus.W & (offset == 2'd0);
    assign ctrl_wr = hit & bus.W & (offset == 2'd1);

    // A pending auto-reload turns the next tick into a reload instead of an expiry.
    assign expire_now = tick & (count_q <= 16'd1) & ~reload_q;

    always_comb begin
        load_d    = load_q;
        count_d   = count_q;
        run_d     = run_q;
        auto_d    = auto_q;
        expired_d = expired_q;
        reload_d  = reload_q;
`ifdef IO_TIMER_PRESCALE_EN
        presc_d = presc_q;
        if (run_q) begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        end
`endif
        if (load_wr) begin
            load_d = bus.DOUT;
        end

        // A CTRL write wins over a coincident tick: the tick's count/RUN effect is dropped.
        if (ctrl_wr) begin
            run_d    = bus.DOUT[0];
            auto_d   = bus.DOUT[1];
            reload_d = reload_q & bus.DOUT[0] & bus.DOUT[1];
            if (bus.DOUT[0] && !run_q) begin
                count_d  = load_q;
                reload_d = 1'b0;
`ifdef IO_TIMER_PRESCALE_EN
                presc_d = '0;
`endif
            end
        end else if (tick) begin
            if (reload_q) begin
                count_d  = load_q;
                reload_d = 1'b0;
            end else if (count_q > 16'd1) begin
                count_d = count_q - 16'd1;
            end else if (count_q == 16'd1) begin
                count_d = 16'd0;
                if (auto_q) begin
                    reload_d = 1'b1;
                end else begin
                    run_d = 1'b0;
                end
            end else begin
                run_d = 1'b0;
            end
        end

        // Expiry still flags on a write edge and beats a simultaneous clear.
        if (ctrl_wr && bus.DOUT[2]) begin
            expired_d = 1'b0;
        end
        if (expire_now) begin
            expired_d = 1'b1;
        end
    end

    always_comb begin
        reg_mux = 16'h0000;
        case (offset)
            2'd0: reg_mux = load_q;
            2'd1: reg_mux = {14'h0000, auto_q, run_q};
            2'd2: reg_mux = count_q;
            2'd3: reg_mux = {14'h0000, run_q, expired_q};
            default: reg_mux = 16'h0000;
        endcase
        rdata_d = hit ? reg_mux : 16'h0000;
        sel_d   = hit & ~bus.W;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            load_q    <= 16'h0000;
            count_q   <= 16'h0000;
            run_q     <= 1'b0;
            auto_q    <= 1'b0;
            expired_q <= 1'b0;
            reload_q  <= 1'b0;
            rdata_q   <= 16'h0000;
            sel_q     <= 1'b0;
        end else begin
            load_q    <= load_d;
            count_q   <= count_d;
            run_q     <= run_d;
            auto_q    <= auto_d;
            expired_q <= expired_d;
            reload_q  <= reload_d;
            rdata_q   <= rdata_d;
            sel_q     <= sel_d;
        end
    end

`ifdef IO_TIMER_PRESCALE_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`endif

    assign bus.RDATA = rdata_q;
    assign bus.SEL   = sel_q;
    assign Expired   = expired_q;

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer; the prescaled build runs the
// PRESCALE=4 timing test, the default build runs the per-cycle tick tests.
module tb_io_timer;

    logic Clock;
    logic Resetn;
    logic Expired;
    int   checks;
    int   errors;

    io_timer_if bus ();

    io_timer #(.BASE(4'h4), .PRESCALE(4)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .bus     (bus.slave),
        .Expired (Expired)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input logic [15:0] addr, input logic [15:0] data, input logic w);
        bus.ADDR = addr;
        bus.DOUT = data;
        bus.W    = w;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    task automatic test_reset;
        chk16("reset_expired", {15'h0, Expired}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(16'h4000 + 16'(i), 16'h0000, 1'b0);
            chk16($sformatf("reset_rdata_off%0d", i), bus.RDATA, 16'h0000);
            chk16($sformatf("reset_sel_off%0d", i), {15'h0, bus.SEL}, 16'h0001);
        end
        step(16'h1002, 16'h0000, 1'b0);
        chk16("miss_sel", {15'h0, bus.SEL}, 16'h0000);
    endtask

`ifdef IO_TIMER_PRESCALE_EN
    task automatic test_prescale;
        step(16'h4000, 16'h0001, 1'b1);
        step(16'h4001, 16'h0001, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(16'h0000, 16'h0000, 1'b0);
            chk16($sformatf("presc_expired_edge%0d", i), {15'h0, Expired}, 16'h0000);
        end
        step(16'h0000, 16'h0000, 1'b0);
        chk16("presc_expired_edge4", {15'h0, Expired}, 16'h0001);
        step(16'h4003, 16'h0000, 1'b0);
        chk16("presc_status", bus.RDATA, 16'h0001);
    endtask
`else
    task automatic test_oneshot;
        step(16'h4000, 16'h0003, 1'b1);
        step(16'h4001, 16'h0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(16'h4002, 16'h0000, 1'b0);
            chk16($sformatf("oneshot_count%0d", i), bus.RDATA, 16'(3 - i));
            if (i == 1) chk16("oneshot_not_yet", {15'h0, Expired}, 16'h0000);
        end
        chk16("oneshot_expired", {15'h0, Expired}, 16'h0001);
        step(16'h4003, 16'h0000, 1'b0);
        chk16("oneshot_status", bus.RDATA, 16'h0001);
        step(16'h4002, 16'h0007, 1'b1);
        step(16'h4002, 16'h0000, 1'b0);
        chk16("count_ro", bus.RDATA, 16'h0000);
        step(16'h4001, 16'h0004, 1'b1);
        chk16("oneshot_clear", {15'h0, Expired}, 16'h0000);
    endtask

    task automatic test_auto;
        step(16'h4000, 16'h0002, 1'b1);
        step(16'h4001, 16'h0003, 1'b1);
        step(16'h4002, 16'h0000, 1'b0);
        chk16("auto_count0", bus.RDATA, 16'h0002);
        step(16'h4002, 16'h0000, 1'b0);
        chk16("auto_count1", bus.RDATA, 16'h0001);
        chk16("auto_expired", {15'h0, Expired}, 16'h0001);
        step(16'h4002, 16'h0000, 1'b0);
        chk16("auto_count2", bus.RDATA, 16'h0000);
        step(16'h4002, 16'h0000, 1'b0);
        chk16("auto_reloaded", bus.RDATA, 16'h0002);
        step(16'h4003, 16'h0000, 1'b0);
        chk16("auto_status", bus.RDATA, 16'h0003);
        step(16'h4001, 16'h0004, 1'b1);
        chk16("auto_stop_clear", {15'h0, Expired}, 16'h0000);
        step(16'h4003, 16'h0000, 1'b0);
        chk16("auto_stopped", bus.RDATA, 16'h0000);
    endtask

    task automatic test_clear_race;
        step(16'h4000, 16'h0001, 1'b1);
        step(16'h4001, 16'h0001, 1'b1);
        step(16'h4001, 16'h0004, 1'b1);
        chk16("race_expired_wins", {15'h0, Expired}, 16'h0001);
        step(16'h4001, 16'h0004, 1'b1);
        chk16("race_later_clear", {15'h0, Expired}, 16'h0000);
        step(16'h4003, 16'h0000, 1'b0);
        chk16("race_status", bus.RDATA, 16'h0000);
    endtask

    task automatic test_reset_midcount;
        step(16'h4000, 16'h0006, 1'b1);
        step(16'h4001, 16'h0001, 1'b1);
        step(16'h4002, 16'h0000, 1'b0);
        chk16("mid_count_pre", bus.RDATA, 16'h0006);
        #2;
        Resetn = 1'b0;
        #1;
        chk16("mid_rdata_async", bus.RDATA, 16'h0000);
        chk16("mid_sel_async", {15'h0, bus.SEL}, 16'h0000);
        chk16("mid_expired_async", {15'h0, Expired}, 16'h0000);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(16'h0000, 16'h0000, 1'b0);
            chk16($sformatf("mid_idle%0d", i), {15'h0, Expired}, 16'h0000);
        end
        step(16'h4002, 16'h0000, 1'b0);
        chk16("mid_count_after", bus.RDATA, 16'h0000);
        step(16'h4000, 16'h0000, 1'b0);
        chk16("mid_load_after", bus.RDATA, 16'h0000);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        Resetn   = 1'b0;
        bus.ADDR = 16'h0000;
        bus.DOUT = 16'h0000;
        bus.W    = 1'b0;
        #12;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        test_reset;
`ifdef IO_TIMER_PRESCALE_EN
        test_prescale;
`else
        test_oneshot;
        test_auto;
        test_clear_race;
        test_reset_midcount;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
